// File: rtl/load_store_unit.sv
// Requester side of the data memory port: word-wide read/write cycles for RISC-V loads and stores,
// with read-modify-write for sub-word stores, load lane extraction/extension and misalignment errors.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | ready for a request; no memory cycle, no response
// S_RD   | read cycle at the aligned address; read word captured at cycle end
// S_WR   | single write cycle of the merged word at the aligned address
// S_RESP | one-cycle response strobe with rdata/err
module load_store_unit #(
   parameter int ADDR_WIDTH  = 32,
   parameter bit ALIGN_CHECK = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_write_data,
   output logic                  mem_write_en,
   output logic                  mem_read_en,
   input  logic [31:0]           mem_read_data
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

   state_t                state_q, state_d;
   logic                  we_q, we_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_write_data_q, mem_write_data_d;
   logic                  mem_write_en_q, mem_write_en_d;
   logic                  mem_read_en_q, mem_read_en_d;
   logic                  resp_valid_q, resp_valid_d;
   logic [31:0]           resp_rdata_q, resp_rdata_d;
   logic                  resp_err_q, resp_err_d;

   logic                  req_bad_f3;
   logic                  req_misalign;
   logic                  req_err;
   logic [ADDR_WIDTH-1:0] req_word_addr;
   logic [ADDR_WIDTH-1:0] lat_word_addr;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           load_val;
   logic [31:0]           merged;

   assign req_bad_f3    = req_we ? (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                                 : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
   assign req_misalign  = ALIGN_CHECK &&
                          (((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                           ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00)));
   assign req_err       = req_bad_f3 || req_misalign;
   assign req_word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
   assign lat_word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

   // Lane extraction and merge; with ALIGN_CHECK=0 addr[0] is simply never consulted for halves.
   always_comb begin
      rd_byte = mem_read_data[{addr_q[1:0], 3'b000} +: 8];
      rd_half = mem_read_data[{addr_q[1], 4'b0000} +: 16];
      case (funct3_q)
         3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
         3'b100:  load_val = {24'h0, rd_byte};
         3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
         3'b101:  load_val = {16'h0, rd_half};
         default: load_val = mem_read_data;
      endcase
      merged = mem_read_data;
      if (funct3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      else                        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q;
   end

   always_comb begin
      state_d          = state_q;
      we_d             = we_q;
      funct3_d         = funct3_q;
      addr_d           = addr_q;
      wdata_d          = wdata_q;
      mem_addr_d       = '0;
      mem_write_data_d = '0;
      mem_write_en_d   = 1'b0;
      mem_read_en_d    = 1'b0;
      resp_valid_d     = 1'b0;
      resp_rdata_d     = '0;
      resp_err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata[15:0];
               if (req_err) begin
                  state_d      = S_RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_we && (req_funct3[1:0] == 2'b10)) begin
                  state_d          = S_WR;
                  mem_write_en_d   = 1'b1;
                  mem_addr_d       = req_word_addr;
                  mem_write_data_d = req_wdata;
               end else begin
                  state_d       = S_RD;
                  mem_read_en_d = 1'b1;
                  mem_addr_d    = req_word_addr;
               end
            end
         end
         S_RD: begin
            if (we_q) begin
               state_d          = S_WR;
               mem_write_en_d   = 1'b1;
               mem_addr_d       = lat_word_addr;
               mem_write_data_d = merged;
            end else begin
               state_d      = S_RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_val;
            end
         end
         S_WR: begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= S_IDLE;
         we_q             <= 1'b0;
         funct3_q         <= '0;
         addr_q           <= '0;
         wdata_q          <= '0;
         mem_addr_q       <= '0;
         mem_write_data_q <= '0;
         mem_write_en_q   <= 1'b0;
         mem_read_en_q    <= 1'b0;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= '0;
         resp_err_q       <= 1'b0;
      end else begin
         state_q          <= state_d;
         we_q             <= we_d;
         funct3_q         <= funct3_d;
         addr_q           <= addr_d;
         wdata_q          <= wdata_d;
         mem_addr_q       <= mem_addr_d;
         mem_write_data_q <= mem_write_data_d;
         mem_write_en_q   <= mem_write_en_d;
         mem_read_en_q    <= mem_read_en_d;
         resp_valid_q     <= resp_valid_d;
         resp_rdata_q     <= resp_rdata_d;
         resp_err_q       <= resp_err_d;
      end
   end

   assign req_ready      = (state_q == S_IDLE);
   assign mem_addr       = mem_addr_q;
   assign mem_write_data = mem_write_data_q;
   assign mem_write_en   = mem_write_en_q;
   assign mem_read_en    = mem_read_en_q;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_err       = resp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic checked against a
// word-array reference model of data memory and the RISC-V load/store rules.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_write_data;
   logic        mem_write_en;
   logic        mem_read_en;
   logic [31:0] mem_read_data;

   int total = 0;
   int bad   = 0;

   load_store_unit #(.ADDR_WIDTH(32), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data),
      .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
      .mem_read_data(mem_read_data)
   );

   always #5 clk = ~clk;

   // data_memory stand-in: 16 words, aliased on address bits [5:2]
   logic [31:0] mem [16];
   logic        pre_en = 1'b0;
   logic [3:0]  pre_idx = 4'h0;
   logic [31:0] pre_data = 32'h0;
   always @(posedge clk) begin
      if (pre_en)            mem[pre_idx] <= pre_data;
      else if (mem_write_en) mem[mem_addr[5:2]] <= mem_write_data;
   end
   assign mem_read_data = mem_read_en ? mem[mem_addr[5:2]] : 32'h0;

   logic [31:0] ref_mem [16];

   int          rd_cycles = 0;
   int          wr_cycles = 0;
   int          resp_cycles = 0;
   int          proto_bad = 0;
   logic [31:0] last_rd_addr = 32'h0;
   logic [31:0] last_wr_addr = 32'h0;
   logic [31:0] last_wr_data = 32'h0;
   always @(negedge clk) begin
      if (mem_read_en) begin rd_cycles++; last_rd_addr = mem_addr; end
      if (mem_write_en) begin wr_cycles++; last_wr_addr = mem_addr; last_wr_data = mem_write_data; end
      if (resp_valid) resp_cycles++;
      if ((mem_read_en && mem_write_en) ||
          ((mem_read_en || mem_write_en) && (req_ready || resp_valid || resp_err)) ||
          ((mem_read_en || mem_write_en) && (mem_addr[1:0] != 2'b00)))
         proto_bad++;
   end

   task automatic preload(input logic [3:0] idx, input logic [31:0] data);
      @(negedge clk);
      pre_en = 1'b1; pre_idx = idx; pre_data = data;
      @(negedge clk);
      pre_en = 1'b0;
      ref_mem[idx] = data;
   endtask

   // Drives one request, returns latency from the accept edge and what the DUT did.
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                          output logic err, output int nrd, output int nwr,
                          output logic [33:0] post);
      int rd0, wr0, k;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
      k = 0;
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      rd0 = rd_cycles; wr0 = wr_cycles;
      lat = 0; rdata = 32'h0; err = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (resp_valid) begin lat = i; rdata = resp_rdata; err = resp_err; break; end
      end
      #2;
      nrd = rd_cycles - rd0; nwr = wr_cycles - wr0;
      @(negedge clk);
      post = {resp_valid, resp_err, resp_rdata};
   endtask

   // Reference behaviour from the load/store rules; updates ref_mem for stores.
   task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                        output logic err, output int nrd, output int nwr,
                        output logic [31:0] wword);
      logic [31:0] w, b, h, mask;
      int unsigned bsh, hsh;
      logic legal, mis;
      w   = ref_mem[a[5:2]];
      bsh = 8 * int'(a[1:0]);
      hsh = 16 * int'(a[1]);
      legal = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5));
      mis   = (((f3 == 3'd1) || (f3 == 3'd5)) && a[0]) || ((f3 == 3'd2) && (a[1:0] != 2'd0));
      err   = !legal || mis;
      rdata = 32'h0; nrd = 0; nwr = 0; wword = 32'h0;
      b = (w >> bsh) & 32'hFF;
      h = (w >> hsh) & 32'hFFFF;
      if (err) lat = 1;
      else if (!we) begin
         lat = 2; nrd = 1;
         case (f3)
            3'd0:    rdata = (b >= 32'd128) ? b - 32'd256 : b;
            3'd4:    rdata = b;
            3'd1:    rdata = (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd5:    rdata = h;
            default: rdata = w;
         endcase
      end else if (f3 == 3'd2) begin
         lat = 2; nwr = 1; wword = wd;
      end else begin
         lat = 3; nrd = 1; nwr = 1;
         if (f3 == 3'd0) begin mask = 32'hFF << bsh;   wword = (w & ~mask) | ((wd & 32'hFF) << bsh); end
         else            begin mask = 32'hFFFF << hsh; wword = (w & ~mask) | ((wd & 32'hFFFF) << hsh); end
      end
      if (!err && we) ref_mem[a[5:2]] = wword;
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++; if ({req_ready, resp_valid, resp_err, mem_read_en, mem_write_en} !== 5'b10000) begin
         bad++; $display("FAIL reset_ctrl: got %b want 10000", {req_ready, resp_valid, resp_err, mem_read_en, mem_write_en}); end
      total++; if ({resp_rdata, mem_addr, mem_write_data} !== 96'h0) begin
         bad++; $display("FAIL reset_data: got %h want 0", {resp_rdata, mem_addr, mem_write_data}); end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 16; i++) preload(4'(i), 32'h0);
      total++; if ({req_ready, resp_valid, mem_read_en, mem_write_en} !== 4'b1000) begin
         bad++; $display("FAIL idle_after_reset: got %b want 1000", {req_ready, resp_valid, mem_read_en, mem_write_en}); end
   endtask

   task automatic test_load_word();
      int lat, nrd, nwr; logic [31:0] rd; logic er; logic [33:0] post;
      preload(4'd1, 32'hAABBCCDD);
      run_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, nrd, nwr, post);
      total++; if (lat !== 2) begin bad++; $display("FAIL lw_latency: got %0d want 2", lat); end
      total++; if (rd !== 32'hAABBCCDD) begin bad++; $display("FAIL lw_rdata: got %h want aabbccdd", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_err: got %b want 0", er); end
      total++; if (nrd !== 1 || nwr !== 0) begin bad++; $display("FAIL lw_mem_cycles: got rd=%0d wr=%0d want rd=1 wr=0", nrd, nwr); end
      total++; if (last_rd_addr !== 32'h4) begin bad++; $display("FAIL lw_addr: got %h want 00000004", last_rd_addr); end
      total++; if (post !== 34'h0) begin bad++; $display("FAIL lw_resp_clear: got %h want 0", post); end
   endtask

   task automatic test_subword_loads();
      logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
      logic [31:0] adr [5] = '{32'h7, 32'h7, 32'h6, 32'h4, 32'h4};
      logic [31:0] exp [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFFAABB, 32'h0000CCDD, 32'hFFFFFFDD};
      int lat, nrd, nwr; logic [31:0] rd; logic er; logic [33:0] post;
      for (int i = 0; i < 5; i++) begin
         preload(4'd1, 32'hAABBCCDD);
         run_req(1'b0, f3s[i], adr[i], 32'h0, lat, rd, er, nrd, nwr, post);
         total++; if (rd !== exp[i]) begin bad++; $display("FAIL subload_rdata[%0d]: got %h want %h", i, rd, exp[i]); end
         total++; if (lat !== 2 || er !== 1'b0 || nrd !== 1 || nwr !== 0) begin
            bad++; $display("FAIL subload_timing[%0d]: got lat=%0d err=%b rd=%0d wr=%0d want 2 0 1 0", i, lat, er, nrd, nwr); end
      end
   endtask

   task automatic test_subword_store();
      int lat, nrd, nwr; logic [31:0] rd; logic er; logic [33:0] post;
      preload(4'd1, 32'hAABBCCDD);
      run_req(1'b1, 3'b000, 32'h5, 32'h12345611, lat, rd, er, nrd, nwr, post);
      total++; if (lat !== 3) begin bad++; $display("FAIL sb_latency: got %0d want 3", lat); end
      total++; if (nrd !== 1 || nwr !== 1) begin bad++; $display("FAIL sb_mem_cycles: got rd=%0d wr=%0d want 1 1", nrd, nwr); end
      total++; if (last_wr_addr !== 32'h4) begin bad++; $display("FAIL sb_wr_addr: got %h want 00000004", last_wr_addr); end
      total++; if (last_wr_data !== 32'hAABB11DD) begin bad++; $display("FAIL sb_wr_data: got %h want aabb11dd", last_wr_data); end
      total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sb_resp: got err=%b rdata=%h want 0 0", er, rd); end
      run_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rd, er, nrd, nwr, post);
      total++; if (rd !== 32'hAABB11DD) begin bad++; $display("FAIL sb_readback: got %h want aabb11dd", rd); end
   endtask

   task automatic test_errors();
      logic        wes [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
      logic [31:0] adr [4] = '{32'h9, 32'h6, 32'h4, 32'h4};
      int lat, nrd, nwr; logic [31:0] rd; logic er; logic [33:0] post;
      for (int i = 0; i < 4; i++) begin
         preload(4'd1, 32'hAABBCCDD);
         run_req(wes[i], f3s[i], adr[i], 32'hDEADBEEF, lat, rd, er, nrd, nwr, post);
         total++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_resp[%0d]: got lat=%0d err=%b rdata=%h want 1 1 0", i, lat, er, rd); end
         total++; if (nrd !== 0 || nwr !== 0) begin bad++; $display("FAIL err_no_mem[%0d]: got rd=%0d wr=%0d want 0 0", i, nrd, nwr); end
      end
      total++; if (mem[1] !== 32'hAABBCCDD) begin bad++; $display("FAIL err_mem_intact: got %h want aabbccdd", mem[1]); end
   endtask

   task automatic test_back_to_back();
      int first_ready, resp1, resp2; logic [31:0] r2data;
      preload(4'd1, 32'hAABBCCDD);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = 32'h11223344;
      @(posedge clk); #1;
      req_we = 1'b0; req_wdata = 32'h0;
      first_ready = -1; resp1 = -1; resp2 = -1; r2data = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            if (resp1 < 0) resp1 = c;
            else if (resp2 < 0) begin resp2 = c; r2data = resp_rdata; end
         end
         if (req_ready && first_ready < 0) begin
            first_ready = c;
            @(posedge clk); #1 req_valid = 1'b0;
         end
      end
      req_valid = 1'b0;
      total++; if (first_ready !== 3) begin bad++; $display("FAIL b2b_second_accept: got cycle %0d want 3", first_ready); end
      total++; if (resp1 !== 2 || resp2 !== 5) begin bad++; $display("FAIL b2b_resp_cycles: got %0d,%0d want 2,5", resp1, resp2); end
      total++; if (r2data !== 32'h11223344) begin bad++; $display("FAIL b2b_rdata: got %h want 11223344", r2data); end
      total++; if (mem[1] !== 32'hAABBCCDD) begin bad++; $display("FAIL b2b_word4: got %h want aabbccdd", mem[1]); end
   endtask

   task automatic test_reset_mid_write();
      int resp0;
      preload(4'd1, 32'hAABBCCDD);
      resp0 = resp_cycles;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h4; req_wdata = 32'h0000BEEF;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      total++; if (mem_write_en !== 1'b1) begin bad++; $display("FAIL rst_wr_cycle: got %b want 1", mem_write_en); end
      #1 rst_n = 1'b0;
      #1;
      total++; if ({mem_write_en, mem_read_en, resp_valid, req_ready} !== 4'b0001) begin
         bad++; $display("FAIL rst_async_clear: got %b want 0001", {mem_write_en, mem_read_en, resp_valid, req_ready}); end
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (mem[1] !== 32'hAABBCCDD) begin bad++; $display("FAIL rst_word4: got %h want aabbccdd", mem[1]); end
      total++; if (resp_cycles !== resp0) begin bad++; $display("FAIL rst_no_resp: got %0d want %0d", resp_cycles, resp0); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
   endtask

   task automatic test_random();
      int lat, nrd, nwr, elat, enrd, enwr; logic [31:0] rd, erd, ew, a, wd; logic er, eer, we; logic [2:0] f3;
      logic [33:0] post;
      for (int i = 0; i < 16; i++) preload(4'(i), $urandom());
      for (int t = 0; t < 80; t++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom();
         wd = $urandom();
         model(we, f3, a, wd, elat, erd, eer, enrd, enwr, ew);
         run_req(we, f3, a, wd, lat, rd, er, nrd, nwr, post);
         total++; if (lat !== elat || er !== eer || rd !== erd) begin
            bad++; $display("FAIL rand_resp[%0d]: we=%b f3=%0d a=%h got lat=%0d err=%b rdata=%h want %0d %b %h", t, we, f3, a, lat, er, rd, elat, eer, erd); end
         total++; if (nrd !== enrd || nwr !== enwr) begin
            bad++; $display("FAIL rand_mem_cycles[%0d]: got rd=%0d wr=%0d want %0d %0d", t, nrd, nwr, enrd, enwr); end
         if (enrd == 1) begin
            total++; if (last_rd_addr !== {a[31:2], 2'b00}) begin bad++; $display("FAIL rand_rd_addr[%0d]: got %h want %h", t, last_rd_addr, {a[31:2], 2'b00}); end
         end
         if (enwr == 1) begin
            total++; if (last_wr_addr !== {a[31:2], 2'b00} || last_wr_data !== ew) begin
               bad++; $display("FAIL rand_write[%0d]: got %h/%h want %h/%h", t, last_wr_addr, last_wr_data, {a[31:2], 2'b00}, ew); end
         end
         total++; if (post !== 34'h0) begin bad++; $display("FAIL rand_resp_clear[%0d]: got %h want 0", t, post); end
      end
      total++; if (proto_bad !== 0) begin bad++; $display("FAIL enable_protocol: got %0d violations want 0", proto_bad); end
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_subword_loads();
      test_subword_store();
      test_errors();
      test_back_to_back();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Requester side of the data memory interface. Sits between the CPU memory stage and data_memory, and turns RISC-V load/store requests into word-wide read/write cycles.
- Handles byte and halfword stores with read-modify-write, since data_memory has no byte enables.
- Performs load extraction and sign/zero extension, detects misalignment, and returns a one-cycle response to the pipeline.

Parameters:
ADDR_WIDTH, 32, width of req_addr and mem_addr.
ALIGN_CHECK, 1, 1 = a misaligned access returns an error with no memory cycle; 0 = low address bits are ignored for halfword/word accesses and the access is treated as aligned.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  32  store data (low byte/half used for SB/SH)
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  32  extended load result; 0 for stores and errors
resp_err  output  1  misaligned or illegal funct3; valid with resp_valid
mem_addr  output  ADDR_WIDTH  word-aligned address to data_memory (bits [1:0] = 00)
mem_write_data  output  32  write word
mem_write_en  output  1  write strobe; data_memory commits on the rising edge
mem_read_en  output  1  read enable
mem_read_data  input  32  data_memory read word, combinational from mem_addr/mem_read_en

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - mem_read_en, mem_write_en, resp_valid and resp_err = 0.
  - mem_addr, mem_write_data and resp_rdata = 0.
  - req_ready = 1 while in IDLE.
- Reset mid-operation aborts the operation immediately. No write is committed and no response is issued.
- All mem_* and resp_* outputs are registered and decoded from the state (Moore).
- States and transitions:
  - IDLE: a request is accepted when req_valid && req_ready. On acceptance, latch we, funct3, addr and wdata.
    - Error (illegal funct3 for the direction, or misalignment with ALIGN_CHECK=1): go to RESP with err=1.
    - Load: go to RD.
    - SW: go to WR, merged word = wdata.
    - SB/SH: go to RD.
  - RD: mem_read_en = 1 and mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}. mem_read_data is captured at the end of the cycle.
    - Load: extract the lane selected by addr[1:0], extend per funct3, go to RESP.
    - Store: merge the wdata byte/half into the captured word at the selected lane, go to WR.
  - WR: mem_write_en = 1 for exactly one cycle with the aligned mem_addr and the merged word, then go to RESP.
  - RESP: resp_valid = 1 for one cycle, with resp_rdata and resp_err held that cycle, then go to IDLE. Response fields return to 0 afterwards.
- Legal funct3:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value is an error.
- Misalignment: H/HU with addr[0] = 1; W with addr[1:0] != 00.
- Byte lane = addr[1:0] (lane 0 = bits [7:0]). Halfword lane = addr[1] (0 = bits [15:0]).
- Latency, measured from the accept edge N: load = resp at N+2, SW = N+2, SB/SH = N+3, error = N+1.
- Throughput: req_ready is low from accept until back in IDLE, so at most one outstanding request. A held req_valid is accepted on the first IDLE cycle.
- mem_read_en and mem_write_en are never high in the same cycle. Neither is high in IDLE or RESP.
- Errors never assert either memory enable.
- Address wrap: no increment is performed, so none occurs. Upper address bits pass through unchanged.

Test Plan:
Memory word at 0x4 is preloaded with 0xAABBCCDD before each scenario.
1. LW 0x4 -> exactly one mem_read_en cycle at mem_addr 0x4; resp_valid at N+2; resp_rdata 0xAABBCCDD; resp_err 0; no write.
2. Sub-word loads:
   - LB 0x7 -> 0xFFFFFFAA
   - LBU 0x7 -> 0x000000AA
   - LH 0x6 -> 0xFFFFAABB
   - LHU 0x4 -> 0x0000CCDD
   - LB 0x4 -> 0xFFFFFFDD
3. SB 0x5 with wdata 0x12345611 -> RD cycle, then one WR cycle at mem_addr 0x4 with data 0xAABB11DD; resp at N+3; LW 0x4 then returns 0xAABB11DD.
4. Error cases, each giving resp_err 1 at N+1, resp_rdata 0, and no mem enable:
   - SH 0x9
   - LW 0x6
   - load funct3 011
   - store funct3 100
5. SW 0x8 with 0x11223344, then LW 0x8 with req_valid held continuously:
   - second request is accepted only after the first RESP returns the unit to IDLE;
   - read returns 0x11223344;
   - word 0x4 is unchanged.
6. Assert rst_n low during the WR cycle of SH 0x4 (wdata 0x0000BEEF):
   - mem_write_en drops before the clock edge;
   - word 0x4 stays 0xAABBCCDD;
   - no resp_valid;
   - req_ready = 1 after release.
